// File: rtl/regfile_seq_pkg.sv
// regfile_seq_pkg: opcodes, instruction field positions and FSM state encoding
// shared by the register-file sequencer.
package regfile_seq_pkg;

    localparam logic [3:0] OP_NOP     = 4'h0;
    localparam logic [3:0] OP_ALU_MIN = 4'h1;
    localparam logic [3:0] OP_ALU_MAX = 4'hB;
    localparam logic [3:0] OP_LDI     = 4'hC;
    localparam logic [3:0] OP_HALT    = 4'hF;

    localparam int OP_LSB = 12;
    localparam int RD_LSB = 8;
    localparam int RS_LSB = 4;
    localparam int RT_LSB = 0;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_DECODE  = 3'd1,
        S_READ    = 3'd2,
        S_CAPTURE = 3'd3,
        S_EXEC    = 3'd4,
        S_WB      = 3'd5,
        S_HALT    = 3'd6
    } seq_state_t;

    function automatic logic is_alu_op(input logic [3:0] op);
        return op >= OP_ALU_MIN && op <= OP_ALU_MAX;
    endfunction

endpackage

// File: rtl/seq_timeout_ctr.sv
// seq_timeout_ctr: counts enabled cycles; expire_o flags the MAX-th enabled cycle.
module seq_timeout_ctr #(
    parameter int MAX = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);
    localparam int W = $clog2(MAX + 1);

    logic [W-1:0] cnt_q, cnt_d;

    assign cnt_d    = clr_i ? '0 : en_i ? cnt_q + W'(1) : cnt_q;
    assign expire_o = en_i && cnt_q == W'(MAX - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/regfile_sequencer.sv
// regfile_sequencer: decode/read/execute/write-back initiator for the 16x16 bank.
// Optional RF_BYPASS_EN: forward the last write-back when rs == rt, skipping READ/CAPTURE.
module regfile_sequencer
    import regfile_seq_pkg::*;
#(
    parameter int ALU_TIMEOUT = 255,
    parameter int IMM_W       = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    input  logic [15:0] instr,
    output logic        instr_ready,
    output logic [3:0]  rf_addr_a,
    output logic [3:0]  rf_addr_b,
    output logic [3:0]  rf_addr_c,
    output logic        rf_rw,
    output logic [15:0] rf_wdata,
    input  logic [15:0] rf_a,
    input  logic [15:0] rf_b,
    output logic [3:0]  alu_op,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic        alu_valid,
    input  logic        alu_done,
    input  logic [15:0] alu_result,
    output logic        halted,
    output logic        err_timeout,
    output logic [2:0]  phase
);
    seq_state_t  state_q, state_d;
    logic [15:0] instr_q, instr_d, alu_a_q, alu_a_d, alu_b_q, alu_b_d, wdata_q, wdata_d;
    logic [3:0]  addr_a_q, addr_a_d, addr_b_q, addr_b_d;
    logic [3:0]  op, rd, rs, rt;
    logic        err_q, err_d, expire, alu_ins, bypass;
    logic [15:0] byp_data;

    assign op      = instr_q[OP_LSB +: 4];
    assign rd      = instr_q[RD_LSB +: 4];
    assign rs      = instr_q[RS_LSB +: 4];
    assign rt      = instr_q[RT_LSB +: 4];
    assign alu_ins = is_alu_op(op);

`ifdef RF_BYPASS_EN
    logic        lwb_valid_q;
    logic [3:0]  lwb_addr_q;
    logic [15:0] lwb_data_q;

    assign bypass   = alu_ins && rs == rt && rs == lwb_addr_q && lwb_valid_q;
    assign byp_data = lwb_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lwb_valid_q <= 1'b0;
            lwb_addr_q  <= '0;
            lwb_data_q  <= '0;
        end else if (rf_rw) begin
            lwb_valid_q <= 1'b1;
            lwb_addr_q  <= rf_addr_c;
            lwb_data_q  <= rf_wdata;
        end
    end
`else
    assign bypass   = 1'b0;
    assign byp_data = '0;
`endif

    seq_timeout_ctr #(.MAX(ALU_TIMEOUT)) u_timeout (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (state_q != S_EXEC),
        .en_i     (state_q == S_EXEC),
        .expire_o (expire)
    );

    always_comb begin
        state_d  = state_q;
        instr_d  = instr_q;
        addr_a_d = addr_a_q;
        addr_b_d = addr_b_q;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        wdata_d  = wdata_q;
        err_d    = 1'b0;
        case (state_q)
            S_IDLE: if (instr_valid) begin
                instr_d = instr;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                addr_a_d = alu_ins ? rs : addr_a_q;
                addr_b_d = alu_ins ? rt : addr_b_q;
                alu_a_d  = bypass ? byp_data : alu_a_q;
                alu_b_d  = bypass ? byp_data : alu_b_q;
                wdata_d  = op == OP_LDI ? 16'(instr_q[IMM_W-1:0]) : wdata_q;
                state_d  = op == OP_NOP ? S_IDLE : bypass ? S_EXEC : alu_ins ? S_READ :
                           op == OP_LDI ? S_WB : op == OP_HALT ? S_HALT : S_IDLE;
            end
            S_READ: state_d = S_CAPTURE;
            S_CAPTURE: begin
                alu_a_d = rf_a;
                alu_b_d = rf_b;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                wdata_d = alu_done ? alu_result : wdata_q;
                err_d   = !alu_done && expire;
                state_d = alu_done ? S_WB : expire ? S_IDLE : S_EXEC;
            end
            S_WB:    state_d = S_IDLE;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            instr_q  <= '0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            instr_q  <= instr_d;
            addr_a_q <= addr_a_d;
            addr_b_q <= addr_b_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            wdata_q  <= wdata_d;
            err_q    <= err_d;
        end
    end

    // Read addresses show up already in DECODE and then hold their last value.
    assign rf_addr_a   = state_q == S_DECODE && alu_ins ? rs : addr_a_q;
    assign rf_addr_b   = state_q == S_DECODE && alu_ins ? rt : addr_b_q;
    assign rf_addr_c   = state_q == S_WB ? rd : '0;
    assign rf_rw       = state_q == S_WB && rd != 4'd0;
    assign rf_wdata    = wdata_q;
    assign instr_ready = state_q == S_IDLE;
    assign alu_op      = op;
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_valid   = state_q == S_EXEC;
    assign halted      = state_q == S_HALT;
    assign err_timeout = err_q;
    assign phase       = state_q;

endmodule

// File: tb/tb_regfile_sequencer.sv
// tb_regfile_sequencer: table-driven checks plus directed multi-cycle sequences
// against a behavioural register bank and ALU.
module tb_regfile_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid, instr_ready, rf_rw, alu_valid, alu_done, halted, err_timeout;
    logic [15:0] instr, rf_wdata, rf_a, rf_b, alu_a, alu_b, alu_result;
    logic [3:0]  rf_addr_a, rf_addr_b, rf_addr_c, alu_op;
    logic [2:0]  phase;
    logic        resp_en;

    logic [15:0] bank [16] = '{1: 16'h0010, 2: 16'h0005, default: 16'h0000};
    int          cyc = 0, wr_n = 0, wr_cyc = 0, bad_rw = 0, acc_cyc = 0;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    int          n_chk = 0, n_fail = 0;

    typedef struct {
        logic [15:0] ins;
        logic        wr;
        logic [3:0]  addr;
        logic [15:0] data;
        int          lat;
    } vec_t;
    vec_t vecs [8];

    regfile_sequencer dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .rf_addr_a(rf_addr_a), .rf_addr_b(rf_addr_b),
        .rf_addr_c(rf_addr_c), .rf_rw(rf_rw), .rf_wdata(rf_wdata), .rf_a(rf_a), .rf_b(rf_b),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_valid(alu_valid),
        .alu_done(alu_done), .alu_result(alu_result), .halted(halted),
        .err_timeout(err_timeout), .phase(phase)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] alu_f(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            4'h1:    return a + b;
            4'h2:    return a - b;
            4'h3:    return a & b;
            4'h4:    return a | b;
            4'h5:    return a ^ b;
            default: return a + b + 16'(op);
        endcase
    endfunction

    assign alu_done   = alu_valid && resp_en;
    assign alu_result = alu_f(alu_op, alu_a, alu_b);

    always @(posedge clk) begin
        rf_a <= bank[rf_addr_a];
        rf_b <= bank[rf_addr_b];
        if (rf_rw) begin
            bank[rf_addr_c] = rf_wdata;
            wr_n++;
            wr_addr = rf_addr_c;
            wr_data = rf_wdata;
            wr_cyc  = cyc;
            if (phase != 3'd5) bad_rw++;
        end
        cyc++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [15:0] ins);
        int i = 0;
        while (!instr_ready && i < 50) begin
            @(negedge clk);
            i++;
        end
        chk("issue_ready", instr_ready, 1);
        instr       = ins;
        instr_valid = 1'b1;
        acc_cyc     = cyc;
        @(negedge clk);
        instr_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (phase != 3'd0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("reach_idle", phase, 0);
    endtask

    task automatic wait_phase(input logic [2:0] target, output int n);
        n = 0;
        while (phase != target && n < 400) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int w0, n, exp_g;
        instr_valid = 1'b0;
        instr       = '0;
        resp_en     = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_ready", instr_ready, 1);
        chk("rst_phase", phase, 0);
        chk("rst_halted", halted, 0);
        chk("rst_err", err_timeout, 0);
        chk("rst_rw", rf_rw, 0);
        chk("rst_alu_valid", alu_valid, 0);
        chk("rst_wdata", rf_wdata, 0);
        chk("rst_alu_a", alu_a, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", instr_ready, 1);

        // operand capture from preloaded r1/r2, alu_done on first EXEC cycle
        issue(16'h1812);
        wait_phase(3'd4, n);
        chk("op_exec_offset", n, 3);
        chk("op_alu_a", alu_a, 16'h0010);
        chk("op_alu_b", alu_b, 16'h0005);
        chk("op_alu_op", alu_op, 4'h1);
        chk("op_alu_valid", alu_valid, 1);
        wait_idle();
        chk("op_wr_addr", wr_addr, 4'd8);
        chk("op_wr_data", wr_data, 16'h0015);
        chk("op_wr_lat", wr_cyc - acc_cyc, 5);

        vecs[0] = '{16'hC3A5, 1'b1, 4'd3, 16'h00A5, 2};
        vecs[1] = '{16'h1412, 1'b1, 4'd4, 16'h0015, 5};
        vecs[2] = '{16'h2512, 1'b1, 4'd5, 16'h000B, 5};
        vecs[3] = '{16'h3643, 1'b1, 4'd6, 16'h0005, 5};
        vecs[4] = '{16'h4913, 1'b1, 4'd9, 16'h00B5, 5};
        vecs[5] = '{16'h0123, 1'b0, 4'd0, 16'h0000, 0};
        vecs[6] = '{16'hD123, 1'b0, 4'd0, 16'h0000, 0};
        vecs[7] = '{16'h5765, 1'b1, 4'd7, 16'h000E, 5};
        for (int i = 0; i < 8; i++) begin
            w0 = wr_n;
            issue(vecs[i].ins);
            wait_idle();
            chk($sformatf("v%0d_wr_count", i), wr_n - w0, {31'd0, vecs[i].wr});
            if (vecs[i].wr) begin
                chk($sformatf("v%0d_wr_addr", i), wr_addr, vecs[i].addr);
                chk($sformatf("v%0d_wr_data", i), wr_data, vecs[i].data);
                chk($sformatf("v%0d_latency", i), wr_cyc - acc_cyc, vecs[i].lat);
            end
        end

        // LDI r0: WB visited without a strobe, ready the cycle after
        w0 = wr_n;
        issue(16'hC0FF);
        @(negedge clk);
        chk("r0_wb_phase", phase, 5);
        chk("r0_wb_rw", rf_rw, 0);
        @(negedge clk);
        chk("r0_ready", instr_ready, 1);
        chk("r0_no_write", wr_n - w0, 0);

        // ALU never answers
        resp_en = 1'b0;
        w0 = wr_n;
        issue(16'h1A12);
        n = 0;
        for (int k = 0; k < 600; k++) begin
            if (phase == 3'd4) n++;
            else if (n > 0) break;
            @(negedge clk);
        end
        chk("to_exec_cycles", n, 255);
        chk("to_err_pulse", err_timeout, 1);
        chk("to_phase_idle", phase, 0);
        @(negedge clk);
        chk("to_err_one_cycle", err_timeout, 0);
        chk("to_no_write", wr_n - w0, 0);
        resp_en = 1'b1;
        issue(16'hCA33);
        wait_idle();
        chk("to_next_count", wr_n - w0, 1);
        chk("to_next_addr", wr_addr, 4'hA);
        chk("to_next_data", wr_data, 16'h0033);

        // HALT then LDI is ignored until reset
        issue(16'hF000);
        @(negedge clk);
        chk("halt_halted", halted, 1);
        chk("halt_ready", instr_ready, 0);
        chk("halt_phase", phase, 6);
        w0 = wr_n;
        instr = 16'hCB55;
        instr_valid = 1'b1;
        repeat (5) @(negedge clk);
        instr_valid = 1'b0;
        chk("halt_sticky", halted, 1);
        chk("halt_ldi_ignored", wr_n - w0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("halt_rst_halted", halted, 0);
        chk("halt_rst_ready", instr_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // async reset while waiting in EXEC
        resp_en = 1'b0;
        w0 = wr_n;
        issue(16'h1B12);
        wait_phase(3'd4, n);
        chk("ar_in_exec", phase, 4);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_phase", phase, 0);
        chk("ar_alu_valid", alu_valid, 0);
        chk("ar_alu_a", alu_a, 0);
        chk("ar_ready", instr_ready, 1);
        chk("ar_wdata", rf_wdata, 0);
        @(negedge clk);
        rst_n = 1'b1;
        resp_en = 1'b1;
        repeat (10) @(negedge clk);
        chk("ar_no_write", wr_n - w0, 0);
        chk("ar_idle", phase, 0);

        // rs == rt on the register just written (forwarded when bypass is built)
`ifdef RF_BYPASS_EN
        exp_g = 1;
`else
        exp_g = 3;
`endif
        issue(16'hC507);
        wait_idle();
        w0 = wr_n;
        issue(16'h1C55);
        wait_phase(3'd4, n);
        chk("byp_exec_offset", n, exp_g);
        chk("byp_alu_a", alu_a, 16'h0007);
        chk("byp_alu_b", alu_b, 16'h0007);
        wait_idle();
        chk("byp_wr_count", wr_n - w0, 1);
        chk("byp_wr_addr", wr_addr, 4'hC);
        chk("byp_wr_data", wr_data, 16'h000E);

        chk("rw_outside_wb", bad_rw, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_sequencer.md
Name: regfile_sequencer

Overview:
- Control-side initiator for the 16x16 register bank.
- Accepts 16-bit instructions, decodes them, and drives the bank's read addresses, then captures the operands one cycle later.
- Hands the operands to the ALU, waits for the result, and issues exactly one write-back strobe (rf_rw) per writing instruction.
- Sits between instruction fetch and the register bank/ALU pair. It is the only block allowed to drive the bank's address and read/write lines.

Parameters:
- ALU_TIMEOUT, 255, maximum EXEC cycles waiting for alu_done before abort (1..255).
- IMM_W, 8, LDI immediate width; the value is zero-extended to 16 bits.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- instr_valid  input  1  an instruction is offered.
- instr  input  16  instruction fields: [15:12] opcode, [11:8] rd, [7:4] rs, [3:0] rt; for LDI, [7:0] is the immediate.
- instr_ready  output  1  sequencer can accept an instruction.
- rf_addr_a  output  4  bank read address A (rs).
- rf_addr_b  output  4  bank read address B (rt).
- rf_addr_c  output  4  bank write address (rd).
- rf_rw  output  1  write strobe; 1 = write rf_wdata to rf_addr_c this edge.
- rf_wdata  output  16  write-back data.
- rf_a  input  16  bank read data A; registered, valid one cycle after the address.
- rf_b  input  16  bank read data B; same timing as rf_a.
- alu_op  output  4  opcode forwarded to the ALU.
- alu_a  output  16  operand A.
- alu_b  output  16  operand B.
- alu_valid  output  1  operands valid; held until alu_done.
- alu_done  input  1  ALU result valid this cycle.
- alu_result  input  16  ALU result.
- halted  output  1  sticky halt indicator.
- err_timeout  output  1  one-cycle pulse when an ALU wait is aborted.
- phase  output  3  current state encoding.

Behaviour:
- Opcodes:
  - 0x0 NOP: no register access.
  - 0x1-0xB: ALU operations, rd <= f(rs, rt).
  - 0xC LDI: rd <= zero-extended immediate.
  - 0xD, 0xE: reserved; treated as NOP.
  - 0xF HALT.
- States and encodings: IDLE=0, DECODE=1, READ=2, CAPTURE=3, EXEC=4, WB=5, HALT=6.
- Reset (async assert, sync-safe release):
  - State returns to IDLE.
  - instr_ready = 1; every other output = 0, including halted, err_timeout and phase.
  - Assertion mid-instruction discards it; no write-back occurs.
- IDLE: instr_ready = 1. On instr_valid && instr_ready, latch instr and go to DECODE.
- DECODE:
  - NOP or reserved -> IDLE.
  - HALT -> HALT.
  - LDI -> WB, with rf_wdata = immediate.
  - ALU op -> drive rf_addr_a = rs, rf_addr_b = rt, go to READ.
- READ: addresses held; the bank registers them at this edge. Go to CAPTURE.
- CAPTURE: latch rf_a into alu_a and rf_b into alu_b. Go to EXEC.
- EXEC:
  - alu_valid = 1 and alu_op held stable.
  - alu_done is accepted on any EXEC cycle, including the first. On it, latch alu_result into rf_wdata and go to WB.
  - A counter increments each EXEC cycle. When it reaches ALU_TIMEOUT without alu_done: pulse err_timeout, skip write-back, go to IDLE.
- WB:
  - rf_addr_c = rd and rf_rw = 1 for exactly one cycle, then IDLE.
  - rd = 0 is a write to R0: rf_rw stays 0 (R0 reads as whatever the bank holds; never written).
- HALT: halted = 1 and instr_ready = 0 until reset. instr_valid is ignored.
- Latency:
  - ALU op with immediate alu_done: accept edge to write edge = 5 cycles.
  - LDI: 2 cycles.
  - Throughput: one instruction in flight; no overlap.
- Read-after-write: a WB then an immediately following READ of the same register sees the new value. Write occurs at WB edge N; READ is no earlier than edge N+2.
- rf_rw is never asserted outside WB.
- Read addresses are don't-care outside READ but held at their last value to limit toggling.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined:
  - Track last_wb_addr/last_wb_data plus a valid bit, set on a committed WB and cleared on reset.
  - In DECODE, if an ALU op has rs == rt == last_wb_addr with valid set, load alu_a = alu_b = last_wb_data and go directly to EXEC, skipping READ and CAPTURE (2 cycles saved).
- Not defined: always take the READ/CAPTURE path. No extra registers are built.

Decomposition:
- Package regfile_seq_pkg holds:
  - opcode constants (OP_NOP, OP_LDI, OP_HALT, OP_ALU_MIN/MAX);
  - state enum seq_state_t with the encodings above;
  - instruction field position constants.
- One sub-module: seq_timeout_ctr, a clear/enable/expire counter sized by ALU_TIMEOUT. Everything else stays inline.

Test Plan:
- LDI r3, 0xA5 after reset:
  - rf_rw = 1 with rf_addr_c = 3 and rf_wdata = 0x00A5 exactly 2 cycles after accept.
  - instr_ready returns high the next cycle.
- Bank preloaded r1 = 0x0010, r2 = 0x0005; issue op 0x1 rd = 4, rs = 1, rt = 2; ALU returns 0x0015 with alu_done on the first EXEC cycle:
  - alu_a = 0x0010, alu_b = 0x0005.
  - Write r4 = 0x0015 at accept + 5 cycles.
- ALU op with alu_done never asserted:
  - err_timeout pulses after 255 EXEC cycles.
  - rf_rw never asserts; next instruction accepted.
- LDI r0, 0xFF:
  - WB cycle occurs with rf_rw = 0.
- HALT followed by LDI:
  - halted = 1, instr_ready = 0, LDI ignored.
  - rst_n pulse clears halted and restores instr_ready = 1.
- rst_n asserted during EXEC:
  - Outputs go to reset values immediately (async).
  - No write-back after release.
  - With RF_BYPASS_EN: LDI r5, 7 then op rs = rt = 5 reaches EXEC 2 cycles earlier, with alu_a = alu_b = 0x0007.
